wb_trace_buffer: RTL and testbench
==================================

# wb_trace_buffer

Parametrised writeback trace capture unit for the `risc_v_cpu` pipeline. It records every architecturally visible register write (rd, data, PC) into a circular buffer. Capture can be gated by an arm command and an optional rd-match trigger. Entries are streamed out oldest-first over a valid/ready port, so register-level checks run in hardware and in the bench instead of through per-cycle console dumps.

## Interface
- `XLEN`, 32: data and PC width.
- `DEPTH`, 16: buffer entries; power of two, ≥2.
- `AW`, 5: register address width.
- `STOP_ON_FULL`, 0: 0 means continuous mode (overwrite oldest when full); 1 means freeze when full.
- `CW`: derived, clog2(`DEPTH`)+1.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `wb_reg_write` in 1: WB stage write enable.
- `wb_rd_addr` in AW: WB destination register.
- `wb_write_data` in XLEN: WB write data.
- `wb_pc` in XLEN: PC of the retiring instruction.
- `cfg_arm` in 1: single-cycle pulse that flushes the buffer and starts arming.
- `cfg_match_en` in 1: 1 means wait for an rd match before capturing.
- `cfg_match_rd` in AW: trigger register address.
- `out_valid` out 1: head entry available.
- `out_ready` in 1: consumer accepts the head entry.
- `out_rd` out AW: head entry rd.
- `out_data` out XLEN: head entry data.
- `out_pc` out XLEN: head entry PC.
- `out_seq` out 16: head entry sequence number.
- `count` out CW: entries held, 0..DEPTH.
- `overflow` out 1: sticky; an event was lost or overwritten since the last arm.
- `state` out 2: 0=IDLE, 1=ARMED, 2=CAPTURE, 3=FROZEN.

## Operation
- Event definition: `wb_reg_write`=1 and `wb_rd_addr`≠0. Writes to x0 are never events.
- Storage: register array of {rd, data, pc, seq}, with write pointer, read pointer and `count`. Pointers wrap modulo DEPTH.
- `out_valid` = (`count`≠0). The `out_*` fields show the entry at the read pointer. A pop occurs when `out_valid` and `out_ready` are both 1.
- Sequence counter: 16 bits, reset to 0 by arm. It increments on every event that is pushed and on every overwrite, and wraps 65535→0. It does not increment for events dropped in FROZEN.

FSM (all transitions on a clock edge):
- IDLE: events are ignored. `cfg_arm` → ARMED.
- ARMED, `cfg_match_en`=0: the first event is captured and the FSM moves → CAPTURE.
- ARMED, `cfg_match_en`=1: events with rd≠`cfg_match_rd` are ignored and not counted. The matching event is captured (seq 0) and the FSM moves → CAPTURE.
- CAPTURE: every event is pushed.
- CAPTURE, full, STOP_ON_FULL=0:
  - An event with no simultaneous pop overwrites the oldest entry (both pointers advance, `count` stays DEPTH) and sets `overflow`.
  - An event with a simultaneous pop is a normal push plus pop, and `overflow` is not set.
- CAPTURE, STOP_ON_FULL=1: when `count` reaches DEPTH → FROZEN.
- FROZEN: events are dropped and each drop sets `overflow`. Pops continue. FROZEN is left only by `cfg_arm`.
- `cfg_arm` in any state:
  - clears pointers, `count`, `overflow` and seq, and moves → ARMED;
  - an event in the same cycle is ignored;
  - a pop in the same cycle is discarded.
- Pops are legal in every state. Push and pop in the same cycle with `count` between 1 and DEPTH-1 leaves `count` unchanged.

## Timing
- Reset (`rst`=0, asynchronous): `state`=IDLE, `count`=0, `out_valid`=0, `overflow`=0, seq=0, pointers=0. `out_rd`/`out_data`/`out_pc`/`out_seq` read 0 because array entry 0 is cleared.
- Push latency: an event sampled at edge N is visible at `out_*` with `out_valid`=1 after edge N, when the buffer was empty.
- A pop at edge N presents the next entry after edge N. Back-to-back pops run one per cycle.
- `count`, `overflow` and `state` are registered and update on the same edge as the causing event.
- Reset asserted mid-capture discards all contents immediately. No output glitches back to stale data after deassertion.

## Test plan
- Arm (no match), `out_ready`=0; retire x1=5 @PC 0x0, x2=3 @0x4, x3=8 @0x8 → `count`=3, `state`=CAPTURE. Then `out_ready`=1 → (1,5,0x0,seq0), (2,3,0x4,seq1), (3,8,0x8,seq2) on consecutive cycles, then `out_valid`=0.
- Arm with match rd=3 on the same program → x1 and x2 are ignored while ARMED. A single entry (3,8,0x8,seq0) is captured, then `state`=CAPTURE.
- DEPTH=4, STOP_ON_FULL=0, six events with data 1..6 and no reads → `count`=4, `overflow`=1. Readout gives data 3,4,5,6 with seq 2,3,4,5.
- DEPTH=4, STOP_ON_FULL=1, six events → `state`=FROZEN, `overflow`=1, readout gives data 1..4 with seq 0..3. A further event after draining is still dropped until `cfg_arm`.
- An x0 write (`wb_reg_write`=1, rd=0) → no entry, seq unchanged. When full in continuous mode, an event and `out_ready`=1 in the same cycle → `count` stays 4 and `overflow` stays 0.
- Assert `rst` low mid-capture with `count`=2 → all outputs 0 and `state`=IDLE asynchronously. After release, events are ignored until `cfg_arm`.

Source files
------------

// File: rtl/wb_trace_buffer.sv
// Writeback trace capture: records register writes {rd, data, pc, seq} into a
// circular buffer and streams them out oldest-first over a valid/ready port.
module wb_trace_buffer #(
    parameter int XLEN         = 32,
    parameter int DEPTH        = 16,
    parameter int AW           = 5,
    parameter int STOP_ON_FULL = 0,
    localparam int CW          = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_reg_write,
    input  logic [AW-1:0]   wb_rd_addr,
    input  logic [XLEN-1:0] wb_write_data,
    input  logic [XLEN-1:0] wb_pc,
    input  logic            cfg_arm,
    input  logic            cfg_match_en,
    input  logic [AW-1:0]   cfg_match_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [AW-1:0]   out_rd,
    output logic [XLEN-1:0] out_data,
    output logic [XLEN-1:0] out_pc,
    output logic [15:0]     out_seq,
    output logic [CW-1:0]   count,
    output logic            overflow,
    output logic [1:0]      state
);

    localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_FROZEN  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d;
    logic [15:0]     seq_q, seq_d;

    logic [AW-1:0]   mem_rd_q   [DEPTH];
    logic [XLEN-1:0] mem_data_q [DEPTH];
    logic [XLEN-1:0] mem_pc_q   [DEPTH];
    logic [15:0]     mem_seq_q  [DEPTH];

    logic wb_event;
    logic full;
    logic do_pop;
    logic push;
    logic overwrite;

    assign wb_event = wb_reg_write && (wb_rd_addr != '0);
    assign full     = (count_q == FULL_CNT);
    assign do_pop   = out_valid && out_ready;

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        seq_d     = seq_q;
        push      = 1'b0;
        overwrite = 1'b0;

        // Arm wins over everything: same-cycle events and pops are discarded.
        if (cfg_arm) begin
            state_d  = S_ARMED;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            seq_d    = '0;
        end else begin
            case (state_q)
                S_ARMED: begin
                    if (wb_event && (!cfg_match_en || (wb_rd_addr == cfg_match_rd))) begin
                        push    = 1'b1;
                        state_d = S_CAPTURE;
                    end
                end
                S_CAPTURE: push  = wb_event;
                S_FROZEN:  ovf_d = ovf_q | wb_event;
                default: ;
            endcase

            overwrite = push && full && !do_pop;

            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
                seq_d    = seq_q + 16'd1;
            end
            if (overwrite) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
                ovf_d    = 1'b1;
            end else if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end

            if (push && !do_pop && !full) begin
                count_d = count_q + CW'(1);
            end else if (!push && do_pop) begin
                count_d = count_q - CW'(1);
            end

            if ((STOP_ON_FULL != 0) && push && (count_d == FULL_CNT)) begin
                state_d = S_FROZEN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            seq_q    <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            seq_q    <= seq_d;
        end
    end

    // Entries are cleared on reset so the head reads zero and never shows stale data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_rd_q[i]   <= '0;
                mem_data_q[i] <= '0;
                mem_pc_q[i]   <= '0;
                mem_seq_q[i]  <= '0;
            end
        end else if (push) begin
            mem_rd_q[wr_ptr_q]   <= wb_rd_addr;
            mem_data_q[wr_ptr_q] <= wb_write_data;
            mem_pc_q[wr_ptr_q]   <= wb_pc;
            mem_seq_q[wr_ptr_q]  <= seq_q;
        end
    end

    assign out_valid = (count_q != '0);
    assign out_rd    = mem_rd_q[rd_ptr_q];
    assign out_data  = mem_data_q[rd_ptr_q];
    assign out_pc    = mem_pc_q[rd_ptr_q];
    assign out_seq   = mem_seq_q[rd_ptr_q];
    assign count     = count_q;
    assign overflow  = ovf_q;
    assign state     = state_q;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed bench for wb_trace_buffer: three instances (DEPTH 4 continuous,
// DEPTH 4 stop-on-full, DEPTH 16 default) share one stimulus stream.
module tb_wb_trace_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        we = 1'b0;
    logic [4:0]  rda = '0;
    logic [31:0] wdata = '0;
    logic [31:0] pc = '0;
    logic        arm = 1'b0;
    logic        men = 1'b0;
    logic [4:0]  mrd = '0;
    logic        rdy = 1'b0;

    logic [2:0]       ov;
    logic [2:0][4:0]  ord;
    logic [2:0][31:0] odata;
    logic [2:0][31:0] opc;
    logic [2:0][15:0] oseq;
    logic [2:0]       oovf;
    logic [2:0][1:0]  ost;
    logic [2:0]       cnt0;
    logic [2:0]       cnt1;
    logic [4:0]       cnt2;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    wb_trace_buffer #(.DEPTH(4), .STOP_ON_FULL(0)) u_cont (
        .clk(clk), .rst(rst), .wb_reg_write(we), .wb_rd_addr(rda), .wb_write_data(wdata),
        .wb_pc(pc), .cfg_arm(arm), .cfg_match_en(men), .cfg_match_rd(mrd),
        .out_valid(ov[0]), .out_ready(rdy), .out_rd(ord[0]), .out_data(odata[0]),
        .out_pc(opc[0]), .out_seq(oseq[0]), .count(cnt0), .overflow(oovf[0]), .state(ost[0])
    );

    wb_trace_buffer #(.DEPTH(4), .STOP_ON_FULL(1)) u_stop (
        .clk(clk), .rst(rst), .wb_reg_write(we), .wb_rd_addr(rda), .wb_write_data(wdata),
        .wb_pc(pc), .cfg_arm(arm), .cfg_match_en(men), .cfg_match_rd(mrd),
        .out_valid(ov[1]), .out_ready(rdy), .out_rd(ord[1]), .out_data(odata[1]),
        .out_pc(opc[1]), .out_seq(oseq[1]), .count(cnt1), .overflow(oovf[1]), .state(ost[1])
    );

    wb_trace_buffer u_def (
        .clk(clk), .rst(rst), .wb_reg_write(we), .wb_rd_addr(rda), .wb_write_data(wdata),
        .wb_pc(pc), .cfg_arm(arm), .cfg_match_en(men), .cfg_match_rd(mrd),
        .out_valid(ov[2]), .out_ready(rdy), .out_rd(ord[2]), .out_data(odata[2]),
        .out_pc(opc[2]), .out_seq(oseq[2]), .count(cnt2), .overflow(oovf[2]), .state(ost[2])
    );

    typedef struct {
        int          inst;
        logic        arm;
        logic        men;
        logic [4:0]  mrd;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] pc;
        logic        rdy;
        logic        ev;
        logic [4:0]  erd;
        logic [31:0] edata;
        logic [31:0] epc;
        logic [15:0] eseq;
        int          ecnt;
        logic        eovf;
        logic [1:0]  est;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int inst, input int a, input int m, input int mr,
                       input int w, input int r, input int d, input int p, input int rr,
                       input int ev, input int erd, input int ed, input int ep, input int es,
                       input int ec, input int eo, input int st);
        vec_t v;
        v.inst = inst; v.arm = (a != 0); v.men = (m != 0); v.mrd = 5'(mr);
        v.we = (w != 0); v.rd = 5'(r); v.data = 32'(d); v.pc = 32'(p); v.rdy = (rr != 0);
        v.ev = (ev != 0); v.erd = 5'(erd); v.edata = 32'(ed); v.epc = 32'(ep);
        v.eseq = 16'(es); v.ecnt = ec; v.eovf = (eo != 0); v.est = 2'(st);
        vecs.push_back(v);
    endtask

    function automatic int cnt_of(input int i);
        case (i)
            0:       return int'(cnt0);
            1:       return int'(cnt1);
            default: return int'(cnt2);
        endcase
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (step %0d): got 0x%0h, expected 0x%0h", nm, idx, act, exp);
        end
    endtask

    task automatic chk_zero(input int idx);
        for (int i = 0; i < 3; i++) begin
            chk("rst_valid", idx, 32'(ov[i]), 32'd0);
            chk("rst_count", idx, 32'(cnt_of(i)), 32'd0);
            chk("rst_state", idx, 32'(ost[i]), 32'd0);
            chk("rst_overflow", idx, 32'(oovf[i]), 32'd0);
            chk("rst_rd", idx, 32'(ord[i]), 32'd0);
            chk("rst_data", idx, odata[i], 32'd0);
            chk("rst_pc", idx, opc[i], 32'd0);
            chk("rst_seq", idx, 32'(oseq[i]), 32'd0);
        end
    endtask

    task automatic drive(input logic a, input logic m, input logic [4:0] mr, input logic w,
                         input logic [4:0] r, input logic [31:0] d, input logic [31:0] p,
                         input logic rr);
        arm = a; men = m; mrd = mr; we = w; rda = r; wdata = d; pc = p; rdy = rr;
    endtask

    initial begin
        vec_t v;
        int   i;

        // inst: 0 = DEPTH4 continuous, 1 = DEPTH4 stop-on-full, 2 = DEPTH16
        // basic capture and in-order readout
        add(2, 0,0,0, 1,1,5,'h0,  0, 0,0,0,0,0,     0,0,0);
        add(2, 1,0,0, 1,1,5,'h0,  0, 0,0,0,0,0,     0,0,1);
        add(2, 0,0,0, 1,1,5,'h0,  0, 1,1,5,'h0,0,   1,0,2);
        add(2, 0,0,0, 1,2,3,'h4,  0, 1,1,5,'h0,0,   2,0,2);
        add(2, 0,0,0, 1,3,8,'h8,  0, 1,1,5,'h0,0,   3,0,2);
        add(2, 0,0,0, 0,0,0,0,    1, 1,2,3,'h4,1,   2,0,2);
        add(2, 0,0,0, 0,0,0,0,    1, 1,3,8,'h8,2,   1,0,2);
        add(2, 0,0,0, 0,0,0,0,    1, 0,0,0,0,0,     0,0,2);
        add(2, 0,0,0, 1,0,'h77,'hc, 0, 0,0,0,0,0,   0,0,2);
        add(2, 0,0,0, 1,4,9,'hc,  0, 1,4,9,'hc,3,   1,0,2);
        // rd-match trigger
        add(2, 1,1,3, 0,0,0,0,    1, 0,0,0,0,0,     0,0,1);
        add(2, 0,1,3, 1,1,5,'h0,  0, 0,0,0,0,0,     0,0,1);
        add(2, 0,1,3, 1,2,3,'h4,  0, 0,0,0,0,0,     0,0,1);
        add(2, 0,1,3, 1,3,8,'h8,  0, 1,3,8,'h8,0,   1,0,2);
        add(2, 0,1,3, 1,1,7,'h10, 0, 1,3,8,'h8,0,   2,0,2);
        // continuous overwrite
        add(0, 1,0,0, 0,0,0,0,    0, 0,0,0,0,0,     0,0,1);
        add(0, 0,0,0, 1,1,1,'h0,  0, 1,1,1,'h0,0,   1,0,2);
        add(0, 0,0,0, 1,2,2,'h4,  0, 1,1,1,'h0,0,   2,0,2);
        add(0, 0,0,0, 1,3,3,'h8,  0, 1,1,1,'h0,0,   3,0,2);
        add(0, 0,0,0, 1,4,4,'hc,  0, 1,1,1,'h0,0,   4,0,2);
        add(0, 0,0,0, 1,5,5,'h10, 0, 1,2,2,'h4,1,   4,1,2);
        add(0, 0,0,0, 1,6,6,'h14, 0, 1,3,3,'h8,2,   4,1,2);
        add(0, 0,0,0, 0,0,0,0,    1, 1,4,4,'hc,3,   3,1,2);
        add(0, 0,0,0, 0,0,0,0,    1, 1,5,5,'h10,4,  2,1,2);
        add(0, 0,0,0, 0,0,0,0,    1, 1,6,6,'h14,5,  1,1,2);
        add(0, 0,0,0, 0,0,0,0,    1, 0,0,0,0,0,     0,1,2);
        // stop-on-full freeze
        add(1, 1,0,0, 0,0,0,0,    0, 0,0,0,0,0,     0,0,1);
        add(1, 0,0,0, 1,1,1,'h0,  0, 1,1,1,'h0,0,   1,0,2);
        add(1, 0,0,0, 1,2,2,'h4,  0, 1,1,1,'h0,0,   2,0,2);
        add(1, 0,0,0, 1,3,3,'h8,  0, 1,1,1,'h0,0,   3,0,2);
        add(1, 0,0,0, 1,4,4,'hc,  0, 1,1,1,'h0,0,   4,0,3);
        add(1, 0,0,0, 1,5,5,'h10, 0, 1,1,1,'h0,0,   4,1,3);
        add(1, 0,0,0, 1,6,6,'h14, 0, 1,1,1,'h0,0,   4,1,3);
        add(1, 0,0,0, 0,0,0,0,    1, 1,2,2,'h4,1,   3,1,3);
        add(1, 0,0,0, 0,0,0,0,    1, 1,3,3,'h8,2,   2,1,3);
        add(1, 0,0,0, 0,0,0,0,    1, 1,4,4,'hc,3,   1,1,3);
        add(1, 0,0,0, 0,0,0,0,    1, 0,0,0,0,0,     0,1,3);
        add(1, 0,0,0, 1,7,7,'h18, 0, 0,0,0,0,0,     0,1,3);
        add(1, 1,0,0, 0,0,0,0,    0, 0,0,0,0,0,     0,0,1);
        add(1, 0,0,0, 1,7,7,'h18, 0, 1,7,7,'h18,0,  1,0,2);
        // full in continuous mode with simultaneous pop: no overflow
        add(0, 1,0,0, 0,0,0,0,    0, 0,0,0,0,0,     0,0,1);
        add(0, 0,0,0, 1,1,1,'h0,  0, 1,1,1,'h0,0,   1,0,2);
        add(0, 0,0,0, 1,2,2,'h4,  0, 1,1,1,'h0,0,   2,0,2);
        add(0, 0,0,0, 1,3,3,'h8,  0, 1,1,1,'h0,0,   3,0,2);
        add(0, 0,0,0, 1,4,4,'hc,  0, 1,1,1,'h0,0,   4,0,2);
        add(0, 0,0,0, 1,5,5,'h10, 1, 1,2,2,'h4,1,   4,0,2);

        rst = 1'b0;
        #8;
        chk_zero(-1);
        @(negedge clk);
        rst = 1'b1;

        for (int k = 0; k < vecs.size(); k++) begin
            v = vecs[k];
            @(negedge clk);
            drive(v.arm, v.men, v.mrd, v.we, v.rd, v.data, v.pc, v.rdy);
            @(posedge clk);
            #1;
            i = v.inst;
            chk("valid", k, 32'(ov[i]), 32'(v.ev));
            chk("count", k, 32'(cnt_of(i)), 32'(v.ecnt));
            chk("overflow", k, 32'(oovf[i]), 32'(v.eovf));
            chk("state", k, 32'(ost[i]), 32'(v.est));
            if (v.ev) begin
                chk("out_rd", k, 32'(ord[i]), 32'(v.erd));
                chk("out_data", k, odata[i], v.edata);
                chk("out_pc", k, opc[i], v.epc);
                chk("out_seq", k, 32'(oseq[i]), 32'(v.eseq));
            end
        end

        // asynchronous reset in the middle of a capture
        @(negedge clk);
        drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 5'd0, 1'b1, 5'd1, 32'h11, 32'h40, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 5'd0, 1'b1, 5'd2, 32'h22, 32'h44, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
        chk("pre_rst_count", 100, 32'(cnt2), 32'd2);
        #2;
        rst = 1'b0;
        #1;
        chk_zero(101);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 1'b0, 5'd0, 1'b1, 5'd3, 32'h33, 32'h48, 1'b0);
        @(posedge clk);
        #1;
        chk("post_rst_count", 102, 32'(cnt2), 32'd0);
        chk("post_rst_state", 102, 32'(ost[2]), 32'd0);
        chk("post_rst_valid", 102, 32'(ov[2]), 32'd0);
        @(negedge clk);
        drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 5'd0, 1'b1, 5'd4, 32'h44, 32'h4c, 1'b0);
        @(posedge clk);
        #1;
        chk("rearm_valid", 103, 32'(ov[2]), 32'd1);
        chk("rearm_rd", 103, 32'(ord[2]), 32'd4);
        chk("rearm_data", 103, odata[2], 32'h44);
        chk("rearm_seq", 103, 32'(oseq[2]), 32'd0);
        chk("rearm_state", 103, 32'(ost[2]), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
